// File: rtl/fpu_cpl_buffer.sv
// In-order completion buffer: out-of-order functional-unit writebacks, in-order retirement,
// plus an accumulated IEEE exception-flag shadow.
module fpu_cpl_buffer #(
  parameter  int DEPTH  = 8,
  parameter  int NUM_WB = 3,
  parameter  int DATA_W = 64,
  localparam int TAG_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  // Handshakes: a transfer happens in a cycle where valid and ready are both high; valid never
  // depends on ready, ready on the alloc side depends only on count and flush_i.
  input  logic                     alloc_valid_i,
  output logic                     alloc_ready_o,
  input  logic [4:0]               alloc_rd_i,
  input  logic                     alloc_wb_int_i,
  output logic [TAG_W-1:0]         alloc_tag_o,
  input  logic [NUM_WB-1:0]        wb_valid_i,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag_i,
  input  logic [NUM_WB*DATA_W-1:0] wb_result_i,
  input  logic [NUM_WB*5-1:0]      wb_flags_i,
  output logic                     ret_valid_o,
  input  logic                     ret_ready_i,
  output logic [TAG_W-1:0]         ret_tag_o,
  output logic [DATA_W-1:0]        ret_result_o,
  output logic [4:0]               ret_flags_o,
  output logic [4:0]               ret_rd_o,
  output logic                     ret_wb_int_o,
  input  logic                     fflags_clr_i,
  output logic [4:0]               fflags_acc_o,
  output logic [CNT_W-1:0]         count_o,
  output logic                     empty_o,
  output logic                     wb_err_o
);

  typedef enum logic [1:0] {S_FREE = 2'd0, S_PEND = 2'd1, S_DONE = 2'd2} e_state_t;

  e_state_t            r_state     [DEPTH];
  e_state_t            w_state_nxt [DEPTH];
  logic [TAG_W:0]      r_head;
  logic [TAG_W:0]      r_tail;
  logic [DATA_W-1:0]   r_result    [DEPTH];
  logic [4:0]          r_flags     [DEPTH];
  logic [4:0]          r_rd        [DEPTH];
  logic [DEPTH-1:0]    r_wb_int;
  logic [4:0]          r_fflags_acc;
  logic                r_wb_err;

  logic [TAG_W-1:0]    w_head_idx;
  logic [TAG_W-1:0]    w_tail_idx;
  logic [CNT_W-1:0]    w_count;
  logic                w_alloc;
  logic                w_retire;
  logic [TAG_W-1:0]    w_wb_tag    [NUM_WB];
  logic [DEPTH-1:0]    w_hit;
  logic [DEPTH-1:0]    w_write;
  logic [DATA_W-1:0]   w_hit_result[DEPTH];
  logic [4:0]          w_hit_flags [DEPTH];
  logic                w_wb_err;

  assign w_head_idx    = r_head[TAG_W-1:0];
  assign w_tail_idx    = r_tail[TAG_W-1:0];
  // Wrap bits make the pointer difference range over 0..DEPTH.
  assign w_count       = CNT_W'(r_tail - r_head);
  assign alloc_ready_o = (w_count < CNT_W'(DEPTH)) & ~flush_i;
  assign w_alloc       = alloc_valid_i & alloc_ready_o;
  assign ret_valid_o   = (r_state[w_head_idx] == S_DONE) & ~flush_i;
  assign w_retire      = ret_valid_o & ret_ready_i;

  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      w_wb_tag[p] = wb_tag_i[p*TAG_W +: TAG_W];
    end
  end

  // Scan ports high to low so the lowest-index port overrides on a shared tag.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_hit[e]        = 1'b0;
      w_hit_result[e] = '0;
      w_hit_flags[e]  = '0;
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && (w_wb_tag[p] == TAG_W'(e))) begin
          w_hit[e]        = 1'b1;
          w_hit_result[e] = wb_result_i[p*DATA_W +: DATA_W];
          w_hit_flags[e]  = wb_flags_i[p*5 +: 5];
        end
      end
      w_write[e] = w_hit[e] & (r_state[e] == S_PEND) & ~flush_i;
    end
  end

  always_comb begin
    w_wb_err = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid_i[p]) begin
        if (r_state[w_wb_tag[p]] != S_PEND) w_wb_err = 1'b1;
        for (int q = 0; q < p; q++) begin
          if (wb_valid_i[q] && (w_wb_tag[q] == w_wb_tag[p])) w_wb_err = 1'b1;
        end
      end
    end
    if (flush_i) w_wb_err = 1'b0;
  end

  // Entry state: register / next-state / outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) r_state[e] <= S_FREE;
    end else begin
      for (int e = 0; e < DEPTH; e++) r_state[e] <= w_state_nxt[e];
    end
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_state_nxt[e] = r_state[e];
      if (w_write[e]) w_state_nxt[e] = S_DONE;
    end
    if (w_alloc)  w_state_nxt[w_tail_idx] = S_PEND;
    if (w_retire) w_state_nxt[w_head_idx] = S_FREE;
    if (flush_i) begin
      for (int e = 0; e < DEPTH; e++) w_state_nxt[e] = S_FREE;
    end
  end

  always_comb begin
    alloc_tag_o  = w_tail_idx;
    ret_tag_o    = w_head_idx;
    ret_result_o = r_result[w_head_idx];
    ret_flags_o  = r_flags[w_head_idx];
    ret_rd_o     = r_rd[w_head_idx];
    ret_wb_int_o = r_wb_int[w_head_idx];
    count_o      = w_count;
    empty_o      = (w_count == '0);
    fflags_acc_o = r_fflags_acc;
    wb_err_o     = r_wb_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + (TAG_W+1)'(1);
      if (w_retire) r_head <= r_head + (TAG_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_result[e] <= '0;
        r_flags[e]  <= '0;
        r_rd[e]     <= '0;
      end
      r_wb_int <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_write[e]) begin
          r_result[e] <= w_hit_result[e];
          r_flags[e]  <= w_hit_flags[e];
        end
      end
      if (w_alloc) begin
        r_rd[w_tail_idx]     <= alloc_rd_i;
        r_wb_int[w_tail_idx] <= alloc_wb_int_i;
      end
    end
  end

  // Clear takes effect before the retiring op's flags are merged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fflags_acc <= '0;
      r_wb_err     <= 1'b0;
    end else begin
      if (fflags_clr_i)  r_fflags_acc <= w_retire ? ret_flags_o : 5'b0;
      else if (w_retire) r_fflags_acc <= r_fflags_acc | ret_flags_o;
      if (w_wb_err) r_wb_err <= 1'b1;
    end
  end

endmodule
